// File: rtl/sha3_sched.sv
// sha3_sched: two-requester message scheduler and block sequencer for the SHA3-256 core.
// Config: define SHA3_SCHED_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module sha3_sched #(
   parameter int BLK_W = 1088,
   parameter int DIG_W = 256
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [1:0]       blk_valid,
   input  logic [BLK_W-1:0] blk_data0,
   input  logic [BLK_W-1:0] blk_data1,
   input  logic [1:0]       blk_last,
   output logic [1:0]       blk_ready,
   output logic [BLK_W-1:0] core_in,
   output logic             core_in_valid,
   output logic             core_more,
   input  logic             core_hash_next,
   input  logic             core_out_valid,
   input  logic [DIG_W-1:0] core_out,
   output logic [1:0]       dig_valid,
   output logic [DIG_W-1:0] dig_data,
   output logic             dig_err,
   output logic             busy
);

   typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic             gnt_q, gnt_d;
   logic             a_vld_q, a_vld_d;
   logic             a_last_q, a_last_d;
   logic [BLK_W-1:0] a_data_q, a_data_d;
   logic             b_vld_q, b_vld_d;
   logic             b_last_q, b_last_d;
   logic [BLK_W-1:0] b_data_q, b_data_d;
   logic             last_acc_q, last_acc_d;
   logic             uflow_q, uflow_d;
   logic [DIG_W-1:0] dig_data_q, dig_data_d;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
   logic             rr_q, rr_d;
`endif

   logic             pick;
   logic             ready_gnt;
   logic             accept;
   logic             launch;
   logic             hn;
   logic             ov;
   logic [BLK_W-1:0] blk_in;
   logic             last_in;

`ifdef SHA3_SCHED_FIXED_PRIO_EN
   assign pick = ~blk_valid[0];
`else
   assign pick = (blk_valid == 2'b11) ? rr_q : blk_valid[1];
`endif

   // Ready depends only on state and buffer flags so it never loops back through blk_valid.
   always_comb begin
      ready_gnt = 1'b0;
      case (state_q)
         S_FILL:  ready_gnt = (~a_vld_q | ~b_vld_q) & ~last_acc_q;
         S_RUN:   ready_gnt = ~b_vld_q & ~last_acc_q;
         default: ready_gnt = 1'b0;
      endcase
   end

   assign blk_in  = gnt_q ? blk_data1 : blk_data0;
   assign last_in = blk_last[gnt_q];
   assign accept  = ready_gnt & blk_valid[gnt_q];
   assign launch  = (state_q == S_FILL) & a_vld_q & (a_last_q | b_vld_q);
   assign ov      = (state_q == S_RUN) & core_out_valid;
   assign hn      = (state_q == S_RUN) & core_hash_next & ~core_out_valid;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM: next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (|blk_valid) state_d = S_FILL;
         S_FILL: if (launch)     state_d = S_RUN;
         S_RUN:  if (ov)         state_d = S_DONE;
         S_DONE:                 state_d = S_IDLE;
         default:                state_d = S_IDLE;
      endcase
   end

   // FSM: outputs
   always_comb begin
      blk_ready     = 2'b00;
      dig_valid     = 2'b00;
      dig_err       = 1'b0;
      if (ready_gnt) blk_ready[gnt_q] = 1'b1;
      if (state_q == S_DONE) begin
         dig_valid[gnt_q] = 1'b1;
         dig_err          = uflow_q;
      end
      core_in_valid = launch;
      core_more     = a_vld_q & ~a_last_q;
      busy          = (state_q != S_IDLE);
   end

   assign core_in  = a_data_q;
   assign dig_data = dig_data_q;

   // Buffer, grant and digest update
   always_comb begin
      gnt_d      = gnt_q;
      a_vld_d    = a_vld_q;
      a_last_d   = a_last_q;
      a_data_d   = a_data_q;
      b_vld_d    = b_vld_q;
      b_last_d   = b_last_q;
      b_data_d   = b_data_q;
      last_acc_d = last_acc_q;
      uflow_d    = uflow_q;
      dig_data_d = dig_data_q;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
      rr_d       = rr_q;
`endif
      if (state_q == S_IDLE && |blk_valid) gnt_d = pick;
      // An empty B at hash_next leaves A in place so the core re-absorbs it.
      if (hn) begin
         if (b_vld_q) begin
            a_data_d = b_data_q;
            a_last_d = b_last_q;
            b_vld_d  = 1'b0;
         end else begin
            uflow_d  = 1'b1;
         end
      end
      if (accept) begin
         if (state_q == S_FILL && !a_vld_q) begin
            a_vld_d  = 1'b1;
            a_data_d = blk_in;
            a_last_d = last_in;
         end else begin
            b_vld_d  = 1'b1;
            b_data_d = blk_in;
            b_last_d = last_in;
         end
         last_acc_d = last_acc_q | last_in;
      end
      if (ov) dig_data_d = core_out;
      if (state_q == S_DONE) begin
         a_vld_d    = 1'b0;
         a_last_d   = 1'b0;
         a_data_d   = '0;
         b_vld_d    = 1'b0;
         last_acc_d = 1'b0;
         uflow_d    = 1'b0;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
         rr_d       = ~gnt_q;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_q      <= 1'b0;
         a_vld_q    <= 1'b0;
         a_last_q   <= 1'b0;
         a_data_q   <= '0;
         b_vld_q    <= 1'b0;
         b_last_q   <= 1'b0;
         last_acc_q <= 1'b0;
         uflow_q    <= 1'b0;
         dig_data_q <= '0;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
         rr_q       <= 1'b0;
`endif
      end else begin
         gnt_q      <= gnt_d;
         a_vld_q    <= a_vld_d;
         a_last_q   <= a_last_d;
         a_data_q   <= a_data_d;
         b_vld_q    <= b_vld_d;
         b_last_q   <= b_last_d;
         last_acc_q <= last_acc_d;
         uflow_q    <= uflow_d;
         dig_data_q <= dig_data_d;
`ifndef SHA3_SCHED_FIXED_PRIO_EN
         rr_q       <= rr_d;
`endif
      end
   end

   // B payload is qualified by b_vld_q, so it needs no reset.
   always_ff @(posedge clk) begin
      b_data_q <= b_data_d;
   end

endmodule
